mips_fetch_unit: RTL and testbench
==================================

# mips_fetch_unit

Instruction-fetch stage of the MIPS pipeline, directly upstream of `mips_instr_mem`. It owns the program counter and drives `prog_counter` into the instruction memory. It captures the returned `instruction` into the IF/ID pipeline register. It applies the stall, branch and jump redirects resolved in the decode stage.

## Interface
Parameters:
- `RESET_PC`, default 32'd0: program counter value loaded on reset. Addresses are word-granular, so the next sequential instruction is PC+1.

Ports:
- `clk`  input  1: single system clock; all state updates on the rising edge.
- `rst_n`  input  1: reset, synchronous and active-low. Sampled only on the `clk` rising edge.
- `instruction`  input  32: word returned by `mips_instr_mem` for the current `prog_counter`. The read is combinational within the cycle.
- `stall`  input  1: hazard unit freeze. Holds the PC and IF/ID.
- `branch_taken`  input  1: conditional branch resolved taken in ID.
- `branch_offset`  input  16: signed word offset of that branch.
- `jump`  input  1: J/JAL resolved in ID.
- `jump_target`  input  26: instr_index field of the jump.
- `prog_counter`  output  32: address presented to the instruction memory.
- `ifid_instr`  output  32: registered instruction for decode.
- `ifid_pc`  output  32: address of `ifid_instr`.
- `ifid_pc_plus1`  output  32: `ifid_pc` + 1, used as the link and branch base.
- `ifid_valid`  output  1: IF/ID holds a real instruction. 0 means bubble.

## Operation
- Next-PC priority, evaluated every cycle, highest first:
  - reset → `RESET_PC`
  - `jump` → {`ifid_pc_plus1`[31:26], `jump_target`}
  - `branch_taken` → `ifid_pc_plus1` + sign_extend32(`branch_offset`)
  - `stall` → hold `prog_counter`
  - otherwise → `prog_counter` + 1
- Redirect means `jump` or `branch_taken`.
- A redirect is honoured only when `ifid_valid`=1. Redirect inputs are ignored while IF/ID holds a bubble.
- IF/ID update:
  - On reset: IF/ID is cleared.
  - On redirect: IF/ID is squashed (`ifid_valid`←0, `ifid_instr`←0). The wrong-path word fetched this cycle is discarded.
  - On stall without redirect: IF/ID holds all fields.
  - Otherwise: `ifid_instr`←`instruction`, `ifid_pc`←`prog_counter`, `ifid_pc_plus1`←`prog_counter`+1, `ifid_valid`←1.
- Simultaneous events:
  - redirect + stall → redirect wins and IF/ID is squashed.
  - `jump` + `branch_taken` → jump wins.
- Arithmetic is 32-bit unsigned modulo 2^32.
  - 32'hFFFF_FFFF + 1 wraps to 0.
  - A branch target below 0 wraps.
  - No fault is raised in either case.
- The unit contains no FSM beyond the valid bit. Effective states are BUBBLE (`ifid_valid`=0) and VALID (`ifid_valid`=1):
  - BUBBLE→VALID on any cycle with no reset and no stall.
  - VALID→BUBBLE on redirect or reset.
  - Stall holds the current state.

## Timing
- Reset values: `prog_counter`=`RESET_PC`, `ifid_instr`=0, `ifid_pc`=0, `ifid_pc_plus1`=0, `ifid_valid`=0.
- Reset asserted mid-operation takes effect on the next rising edge. Redirect and stall inputs in that cycle are ignored.
- Fetch latency is 1 cycle. The word at `prog_counter` in cycle N appears on `ifid_*` in cycle N+1.
- Redirect penalty is 1 bubble. The target is presented on `prog_counter` in the cycle after the redirect. The first target instruction is valid in IF/ID one cycle later.
- `stall` must be driven from registered or ID-stage logic. The unit adds no combinational path from `stall` to `prog_counter`; only the next-PC is affected.

## Configuration
- `FETCH_PERF_CNT_EN`:
  - When defined, the unit adds `perf_fetched` (output 32) and `perf_stalls` (output 32). Both reset to 0.
  - `perf_fetched` increments on every IF/ID load with `ifid_valid`←1.
  - `perf_stalls` increments on every cycle with `stall`=1 and no redirect.
  - Both counters wrap at 2^32.
  - When undefined, the ports and counters are absent. All other behaviour is identical.

## Test plan
- Reset, then 5 free-running cycles with the memory returning `instruction`=PC+32'hA000 → `prog_counter` steps 0,1,2,3,4,5. `ifid_pc` lags by one cycle; `ifid_instr`=32'hA000+`ifid_pc`; `ifid_valid`=1 from the second edge.
- `stall` held 2 cycles while `ifid_pc`=3 → `prog_counter` stays 4 and IF/ID holds PC 3. Fetch resumes at 4, then 5.
- `branch_taken` with offset 16'hFFFE at `ifid_pc`=6 → `prog_counter`=5 next cycle and one bubble appears. Then `ifid_pc`=5 with `ifid_valid`=1.
- `jump` with `jump_target`=26'h100 plus `branch_taken` plus `stall`, all with `ifid_pc_plus1`=32'h0400_0008 → `prog_counter`=32'h0400_0100 and IF/ID is squashed.
- `RESET_PC`=32'hFFFF_FFFE, 3 free cycles → `prog_counter` sequence FFFF_FFFE, FFFF_FFFF, 0. Then `rst_n`=0 mid-stream → all outputs return to their reset values on that edge.
- With `FETCH_PERF_CNT_EN` defined: 10 cycles containing 3 stalls and 1 redirect → `perf_stalls`=3, and `perf_fetched` equals the number of valid IF/ID loads.

Source files
------------

// File: rtl/mips_fetch_unit.sv
// Purpose: MIPS instruction-fetch stage; owns the PC and the IF/ID pipeline register.
// Latency: 1 cycle from prog_counter to ifid_*; a taken redirect costs one bubble.
// Backpressure: stall freezes PC and IF/ID; redirect (jump/branch) beats stall and squashes IF/ID.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   instruction              word read combinationally from mips_instr_mem at prog_counter
//   stall                    hazard freeze (must come from registered / ID-stage logic)
//   branch_taken/offset      taken conditional branch from ID, signed word offset
//   jump/jump_target         J/JAL from ID, 26-bit instr_index
//   prog_counter             fetch address to instruction memory
//   ifid_instr/pc/pc_plus1   IF/ID register contents
//   ifid_valid               IF/ID holds a real instruction (0 = bubble)
// Optional feature macro: FETCH_PERF_CNT_EN adds perf_fetched / perf_stalls counters.
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  output logic [31:0] prog_counter,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus1,
  output logic        ifid_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stalls
`endif
);

  logic        redirect;
  logic        load_ifid;
  logic [31:0] pc_plus1;
  logic [31:0] branch_sext;
  logic [31:0] nxt_pc;
  logic [31:0] nxt_instr;
  logic [31:0] nxt_ifid_pc;
  logic [31:0] nxt_ifid_pc_plus1;
  logic        nxt_valid;

  // Redirect inputs describe the instruction sitting in IF/ID, so they are
  // meaningless while IF/ID holds a bubble.
  assign redirect    = ifid_valid & (jump | branch_taken);
  assign pc_plus1    = prog_counter + 32'd1;
  assign branch_sext = {{16{branch_offset[15]}}, branch_offset};

  always_comb begin
    nxt_pc            = pc_plus1;
    nxt_instr         = ifid_instr;
    nxt_ifid_pc       = ifid_pc;
    nxt_ifid_pc_plus1 = ifid_pc_plus1;
    nxt_valid         = ifid_valid;
    load_ifid         = 1'b0;
    if (redirect) begin
      // Jump outranks branch; the word fetched this cycle is on the wrong path.
      if (jump) begin
        nxt_pc = {ifid_pc_plus1[31:26], jump_target};
      end else begin
        nxt_pc = ifid_pc_plus1 + branch_sext;
      end
      nxt_valid = 1'b0;
      nxt_instr = 32'd0;
    end else if (stall) begin
      nxt_pc = prog_counter;
    end else begin
      load_ifid         = 1'b1;
      nxt_instr         = instruction;
      nxt_ifid_pc       = prog_counter;
      nxt_ifid_pc_plus1 = pc_plus1;
      nxt_valid         = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prog_counter  <= RESET_PC;
      ifid_instr    <= 32'd0;
      ifid_pc       <= 32'd0;
      ifid_pc_plus1 <= 32'd0;
      ifid_valid    <= 1'b0;
    end else begin
      prog_counter  <= nxt_pc;
      ifid_instr    <= nxt_instr;
      ifid_pc       <= nxt_ifid_pc;
      ifid_pc_plus1 <= nxt_ifid_pc_plus1;
      ifid_valid    <= nxt_valid;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched <= 32'd0;
      perf_stalls  <= 32'd0;
    end else begin
      if (load_ifid) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (stall && !redirect) begin
        perf_stalls <= perf_stalls + 32'd1;
      end
    end
  end
`else
  // Without counters the load strobe has no consumer.
  logic unused_load;
  assign unused_load = load_ifid;
`endif

endmodule

// File: tb/tb_mips_fetch_unit.sv
module tb_mips_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, branch_taken, jump;
  logic [15:0] branch_offset;
  logic [25:0] jump_target;

  logic [31:0] a_instr, a_pc, a_iinstr, a_ipc, a_ipp1;
  logic        a_valid;
  logic [31:0] b_instr, b_pc, b_iinstr, b_ipc, b_ipp1;
  logic        b_valid;
  logic [31:0] c_instr, c_pc, c_iinstr, c_ipc, c_ipp1;
  logic        c_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] a_pf, a_ps, b_pf, b_ps, c_pf, c_ps;
`endif

  // Instruction memory model: word at address p is p + 'hA000.
  assign a_instr = a_pc + 32'hA000;
  assign b_instr = b_pc + 32'hA000;
  assign c_instr = c_pc + 32'hA000;

  always #5 clk = ~clk;

  mips_fetch_unit #(.RESET_PC(32'd0)) u_a (
    .clk(clk), .rst_n(rst_n), .instruction(a_instr), .stall(stall),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .jump_target(jump_target), .prog_counter(a_pc),
    .ifid_instr(a_iinstr), .ifid_pc(a_ipc), .ifid_pc_plus1(a_ipp1), .ifid_valid(a_valid)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(a_pf), .perf_stalls(a_ps)
`endif
  );

  mips_fetch_unit #(.RESET_PC(32'h0400_0007)) u_b (
    .clk(clk), .rst_n(rst_n), .instruction(b_instr), .stall(stall),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .jump_target(jump_target), .prog_counter(b_pc),
    .ifid_instr(b_iinstr), .ifid_pc(b_ipc), .ifid_pc_plus1(b_ipp1), .ifid_valid(b_valid)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(b_pf), .perf_stalls(b_ps)
`endif
  );

  mips_fetch_unit #(.RESET_PC(32'hFFFF_FFFE)) u_c (
    .clk(clk), .rst_n(rst_n), .instruction(c_instr), .stall(stall),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .jump_target(jump_target), .prog_counter(c_pc),
    .ifid_instr(c_iinstr), .ifid_pc(c_ipc), .ifid_pc_plus1(c_ipp1), .ifid_valid(c_valid)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(c_pf), .perf_stalls(c_ps)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model of instance u_a (RESET_PC = 0), stated directly from the
  // next-PC priority list and IF/ID update rules.
  logic [31:0] m_pc = 0, m_instr = 0, m_ipc = 0, m_ipp1 = 0;
  logic        m_valid = 0;
  int unsigned m_fetched = 0, m_stalls = 0;

  task automatic model_step();
    logic [31:0] npc;
    if (!rst_n) begin
      m_pc = 0; m_instr = 0; m_ipc = 0; m_ipp1 = 0; m_valid = 0;
      m_fetched = 0; m_stalls = 0;
    end else if (m_valid && (jump || branch_taken)) begin
      if (jump) npc = {m_ipp1[31:26], jump_target};
      else      npc = m_ipp1 + {{16{branch_offset[15]}}, branch_offset};
      m_valid = 0; m_instr = 0;
      m_pc = npc;
    end else if (stall) begin
      m_stalls++;
    end else begin
      m_instr = m_pc + 32'hA000;
      m_ipc   = m_pc;
      m_ipp1  = m_pc + 1;
      m_valid = 1;
      m_fetched++;
      m_pc = m_pc + 1;
    end
  endtask

  // Drive one cycle of inputs, clock it, and leave time at the falling edge for sampling.
  task automatic apply(input logic r, input logic s, input logic b, input logic [15:0] off,
                       input logic j, input logic [25:0] tgt);
    rst_n = r; stall = s; branch_taken = b; branch_offset = off; jump = j; jump_target = tgt;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  typedef struct {
    logic        r, s, b, j;
    logic [15:0] off;
    logic [25:0] tgt;
    logic [31:0] e_pc, e_ipc;
    logic        e_valid;
  } vec_t;

  vec_t vecs[19];

  initial begin
    rst_n = 0; stall = 0; branch_taken = 0; jump = 0; branch_offset = 0; jump_target = 0;
    //           r  s  b  j  off        tgt           e_pc           e_ipc          e_valid
    vecs[0]  = '{0, 0, 0, 0, 16'h0,    26'h0,       32'd0,         32'd0,         1'b0};
    vecs[1]  = '{1, 0, 0, 0, 16'h0,    26'h0,       32'd1,         32'd0,         1'b1};
    vecs[2]  = '{1, 0, 0, 0, 16'h0,    26'h0,       32'd2,         32'd1,         1'b1};
    vecs[3]  = '{1, 0, 0, 0, 16'h0,    26'h0,       32'd3,         32'd2,         1'b1};
    vecs[4]  = '{1, 0, 0, 0, 16'h0,    26'h0,       32'd4,         32'd3,         1'b1};
    vecs[5]  = '{1, 1, 0, 0, 16'h0,    26'h0,       32'd4,         32'd3,         1'b1};
    vecs[6]  = '{1, 1, 0, 0, 16'h0,    26'h0,       32'd4,         32'd3,         1'b1};
    vecs[7]  = '{1, 0, 0, 0, 16'h0,    26'h0,       32'd5,         32'd4,         1'b1};
    vecs[8]  = '{1, 0, 0, 0, 16'h0,    26'h0,       32'd6,         32'd5,         1'b1};
    vecs[9]  = '{1, 0, 0, 0, 16'h0,    26'h0,       32'd7,         32'd6,         1'b1};
    vecs[10] = '{1, 0, 1, 0, 16'hFFFE, 26'h0,       32'd5,         32'd0,         1'b0};
    vecs[11] = '{1, 0, 0, 0, 16'h0,    26'h0,       32'd6,         32'd5,         1'b1};
    vecs[12] = '{1, 0, 1, 0, 16'hFFF0, 26'h0,       32'hFFFF_FFF6, 32'd0,         1'b0};
    vecs[13] = '{1, 0, 0, 0, 16'h0,    26'h0,       32'hFFFF_FFF7, 32'hFFFF_FFF6, 1'b1};
    vecs[14] = '{1, 0, 0, 1, 16'h0,    26'h3FF_FFFF, 32'hFFFF_FFFF, 32'd0,        1'b0};
    vecs[15] = '{1, 0, 0, 0, 16'h0,    26'h0,       32'd0,         32'hFFFF_FFFF, 1'b1};
    vecs[16] = '{0, 1, 1, 1, 16'h7,    26'h55,      32'd0,         32'd0,         1'b0};
    vecs[17] = '{1, 0, 0, 1, 16'h0,    26'h55,      32'd1,         32'd0,         1'b1};
    vecs[18] = '{1, 1, 0, 0, 16'h0,    26'h0,       32'd1,         32'd0,         1'b1};

    @(negedge clk);
    for (int i = 0; i < 19; i++) begin
      apply(vecs[i].r, vecs[i].s, vecs[i].b, vecs[i].off, vecs[i].j, vecs[i].tgt);
      chk($sformatf("vec%0d pc", i), a_pc, vecs[i].e_pc);
      chk($sformatf("vec%0d valid", i), {31'd0, a_valid}, {31'd0, vecs[i].e_valid});
      chk($sformatf("vec%0d instr", i), a_iinstr,
          vecs[i].e_valid ? vecs[i].e_ipc + 32'hA000 : 32'd0);
      if (vecs[i].e_valid || !vecs[i].r) begin
        chk($sformatf("vec%0d ifid_pc", i), a_ipc, vecs[i].e_ipc);
        chk($sformatf("vec%0d ifid_pc_plus1", i), a_ipp1,
            vecs[i].r ? vecs[i].e_ipc + 32'd1 : 32'd0);
      end
    end

    // Jump + branch + stall together: jump wins, IF/ID squashed.
    apply(0, 0, 0, 16'h0, 0, 26'h0);
    apply(1, 0, 0, 16'h0, 1, 26'h100);          // bubble: jump ignored
    chk("b bubble_pc", b_pc, 32'h0400_0008);
    chk("b pc_plus1", b_ipp1, 32'h0400_0008);
    chk("b valid", {31'd0, b_valid}, 32'd1);
    apply(1, 1, 1, 16'h5, 1, 26'h100);
    chk("b jump_pc", b_pc, 32'h0400_0100);
    chk("b squash_valid", {31'd0, b_valid}, 32'd0);
    chk("b squash_instr", b_iinstr, 32'd0);
    apply(1, 0, 0, 16'h0, 0, 26'h0);
    chk("b target_ipc", b_ipc, 32'h0400_0100);
    chk("b target_instr", b_iinstr, 32'h0400_A100);

    // PC wrap at 2^32, then reset mid-stream with redirect/stall ignored.
    apply(0, 0, 0, 16'h0, 0, 26'h0);
    chk("c reset_pc", c_pc, 32'hFFFF_FFFE);
    apply(1, 0, 0, 16'h0, 0, 26'h0);
    chk("c pc1", c_pc, 32'hFFFF_FFFF);
    apply(1, 0, 0, 16'h0, 0, 26'h0);
    chk("c pc_wrap", c_pc, 32'd0);
    chk("c ipc", c_ipc, 32'hFFFF_FFFF);
    chk("c ipp1_wrap", c_ipp1, 32'd0);
    apply(0, 1, 1, 16'h3, 1, 26'h9);
    chk("c rst_pc", c_pc, 32'hFFFF_FFFE);
    chk("c rst_instr", c_iinstr, 32'd0);
    chk("c rst_ipc", c_ipc, 32'd0);
    chk("c rst_ipp1", c_ipp1, 32'd0);
    chk("c rst_valid", {31'd0, c_valid}, 32'd0);

`ifdef FETCH_PERF_CNT_EN
    // 10 cycles: 3 stalls, 1 redirect, 6 valid loads.
    apply(0, 0, 0, 16'h0, 0, 26'h0);
    chk("perf rst_fetched", a_pf, 32'd0);
    chk("perf rst_stalls", a_ps, 32'd0);
    for (int i = 0; i < 3; i++) apply(1, 0, 0, 16'h0, 0, 26'h0);
    for (int i = 0; i < 3; i++) apply(1, 1, 0, 16'h0, 0, 26'h0);
    apply(1, 0, 1, 16'h0, 0, 26'h0);
    for (int i = 0; i < 3; i++) apply(1, 0, 0, 16'h0, 0, 26'h0);
    chk("perf stalls", a_ps, 32'd3);
    chk("perf fetched", a_pf, 32'd6);
`endif

    // Randomized traffic against the reference model.
    apply(0, 0, 0, 16'h0, 0, 26'h0);
    for (int i = 0; i < 600; i++) begin
      logic [31:0] rnd;
      rnd = $urandom;
      apply(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 5) == 0), rnd[15:0],
            ($urandom_range(0, 7) == 0), {rnd[31:16], rnd[9:0]});
      chk($sformatf("rnd%0d pc", i), a_pc, m_pc);
      chk($sformatf("rnd%0d valid", i), {31'd0, a_valid}, {31'd0, m_valid});
      chk($sformatf("rnd%0d instr", i), a_iinstr, m_instr);
      if (m_valid) begin
        chk($sformatf("rnd%0d ipc", i), a_ipc, m_ipc);
        chk($sformatf("rnd%0d ipp1", i), a_ipp1, m_ipp1);
      end
    end
`ifdef FETCH_PERF_CNT_EN
    chk("rnd perf_fetched", a_pf, m_fetched);
    chk("rnd perf_stalls", a_ps, m_stalls);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
